// File: rtl/rs_syndrome_calc.sv
// Streaming Reed-Solomon syndrome generator over GF(256): Horner accumulation of S_j = r(alpha^j).
// Optional saturating error-codeword counter is built when RS_SYND_ERRCNT_EN is defined.
module rs_syndrome_calc #(
  parameter int         N_SYM   = 32,
  parameter int         N_SYND  = 4,
  parameter logic [8:0] GF_POLY = 9'h11D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_synd,
  output logic [3:0]  out_idx,
  output logic        out_last,
  output logic        out_nz,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] err_cnt
);

  localparam int CW = $clog2(N_SYM);
  localparam int IW = (N_SYND > 1) ? $clog2(N_SYND) : 1;

  localparam logic [0:0] ST_ACC = 1'b0;
  localparam logic [0:0] ST_OUT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          live_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    acc_q [N_SYND];
  logic [7:0]    acc_d [N_SYND];
  logic          in_fire, out_fire, last_idx;

  // Multiply by alpha^p; with constant p each call elaborates to a fixed XOR network.
  function automatic logic [7:0] mul_alpha_pow(input logic [7:0] a, input int unsigned p);
    logic [7:0] r;
    r = a;
    for (int k = 0; k < 16; k++) begin
      if (k < p) r = {r[6:0], 1'b0} ^ (r[7] ? GF_POLY[7:0] : 8'h00);
    end
    return r;
  endfunction

  // Both ports use strict valid/ready: a beat moves on a rising edge where valid and ready
  // are both high; flush wins over either transfer in the same cycle.
  assign in_ready  = live_q && (state_q == ST_ACC);
  assign out_valid = (state_q == ST_OUT);
  assign in_fire   = in_valid && in_ready && !flush;
  assign out_fire  = out_valid && out_ready && !flush;
  assign last_idx  = (idx_q == IW'(N_SYND - 1));

  assign out_synd  = acc_q[idx_q];
  assign out_idx   = 4'(idx_q);
  assign out_last  = out_valid && last_idx;

  always_comb begin
    out_nz = 1'b0;
    for (int j = 0; j < N_SYND; j++) out_nz = out_nz | (|acc_q[j]);
    out_nz = out_nz && out_valid;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    for (int j = 0; j < N_SYND; j++) acc_d[j] = acc_q[j];
    if (flush) begin
      state_d = ST_ACC;
      cnt_d   = '0;
      idx_d   = '0;
      for (int j = 0; j < N_SYND; j++) acc_d[j] = 8'h00;
    end else if (in_fire) begin
      for (int j = 0; j < N_SYND; j++) acc_d[j] = mul_alpha_pow(acc_q[j], j) ^ in_data;
      if (cnt_q == CW'(N_SYM - 1)) begin
        cnt_d   = '0;
        state_d = ST_OUT;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (out_fire) begin
      if (last_idx) begin
        idx_d   = '0;
        state_d = ST_ACC;
        for (int j = 0; j < N_SYND; j++) acc_d[j] = 8'h00;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      live_q  <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      for (int j = 0; j < N_SYND; j++) acc_q[j] <= 8'h00;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      for (int j = 0; j < N_SYND; j++) acc_q[j] <= acc_d[j];
    end
  end

`ifdef RS_SYND_ERRCNT_EN
  logic [15:0] err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 16'h0000;
    end else if (out_fire && last_idx && out_nz && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'h0001;
    end
  end
  assign err_cnt = err_q;
`else
  assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Randomized self-checking bench for rs_syndrome_calc against a direct polynomial-evaluation model.
module tb_rs_syndrome_calc;
  localparam int N_SYM  = 32;
  localparam int N_SYND = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_last, out_nz, out_valid;
  logic [7:0]  out_synd;
  logic [3:0]  out_idx;
  logic [15:0] err_cnt;

  rs_syndrome_calc #(.N_SYM(N_SYM), .N_SYND(N_SYND), .GF_POLY(9'h11D)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_synd(out_synd), .out_idx(out_idx), .out_last(out_last), .out_nz(out_nz),
    .out_valid(out_valid), .out_ready(out_ready), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic       exp_nz = 1'b0;
  int         exp_err = 0;
  logic [7:0] cw_buf [N_SYM];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h @%0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      y = y >> 1;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return p;
  endfunction

  // S_j = sum_i r_i * alpha^(j*deg_i); first symbol carries degree N_SYM-1.
  task automatic model_push();
    logic [7:0] s, t;
    logic nz;
    nz = 1'b0;
    for (int j = 0; j < N_SYND; j++) begin
      s = 8'h00;
      for (int i = 0; i < N_SYM; i++) begin
        t = 8'h01;
        for (int k = 0; k < j * (N_SYM - 1 - i); k++) t = gf_mul(t, 8'h02);
        s = s ^ gf_mul(cw_buf[i], t);
      end
      exp_q.push_back(s);
      nz = nz | (s != 8'h00);
    end
    exp_nz = nz;
  endtask

  task automatic fill(input int mode, input int pos, input logic [7:0] val);
    for (int i = 0; i < N_SYM; i++) cw_buf[i] = (mode == 1) ? 8'($urandom_range(0, 255)) : 8'h00;
    if (mode == 2) cw_buf[pos] = val;
  endtask

  task automatic send_sym(input logic [7:0] d, input bit gaps);
    int waited;
    if (gaps && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_data  = d;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 50) chk("in_ready_timeout", 16'(in_ready), 16'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_cw(input bit gaps);
    model_push();
    for (int i = 0; i < N_SYM; i++) send_sym(cw_buf[i], gaps);
    chk("latency_out_valid", 16'(out_valid), 16'd1);
    chk("busy_in_ready", 16'(in_ready), 16'd0);
  endtask

  task automatic read_cw(input int stall, input bit rnd);
    int  cyc;
    bit  rdy, done;
    for (int k = 0; k < N_SYND; k++) begin
      cyc = 0; done = 0;
      while (!done) begin
        if (cyc < stall && k == 0) rdy = 1'b0;
        else if (rnd && cyc < 40) rdy = ($urandom_range(0, 2) != 0);
        else rdy = 1'b1;
        out_ready = rdy;
        chk("out_valid", 16'(out_valid), 16'd1);
        chk("out_idx", 16'(out_idx), 16'(k));
        chk("out_synd", 16'(out_synd), 16'(exp_q[0]));
        chk("out_last", 16'(out_last), 16'(k == N_SYND - 1));
        chk("out_nz", 16'(out_nz), 16'(exp_nz));
        chk("in_ready_readout", 16'(in_ready), 16'd0);
        @(posedge clk); #1;
        cyc++;
        if (rdy) done = 1;
      end
      void'(exp_q.pop_front());
    end
    out_ready = 1'b0;
`ifdef RS_SYND_ERRCNT_EN
    if (exp_nz && exp_err < 65535) exp_err++;
`endif
    chk("bubble_out_valid", 16'(out_valid), 16'd0);
    chk("bubble_in_ready", 16'(in_ready), 16'd1);
    chk("err_cnt", err_cnt, 16'(exp_err));
  endtask

  initial begin
    #2;
    chk("rst_in_ready", 16'(in_ready), 16'd0);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_out_synd", 16'(out_synd), 16'd0);
    chk("rst_out_idx", 16'(out_idx), 16'd0);
    chk("rst_out_last", 16'(out_last), 16'd0);
    chk("rst_out_nz", 16'(out_nz), 16'd0);
    chk("rst_err_cnt", err_cnt, 16'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("exit_rst_in_ready", 16'(in_ready), 16'd1);

    fill(0, 0, 8'h00);  send_cw(0); read_cw(0, 0);
    fill(2, 30, 8'h01); send_cw(0); read_cw(0, 0);
    fill(2, 31, 8'h55); send_cw(0); read_cw(0, 0);
    fill(1, 0, 8'h00);  send_cw(1); read_cw(5, 0);

    // Abort a partial codeword; the sideband symbol on the flush cycle must be dropped.
    for (int i = 0; i < 10; i++) send_sym(8'($urandom_range(1, 255)), 0);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_acc_in_ready", 16'(in_ready), 16'd1);
    chk("flush_acc_out_valid", 16'(out_valid), 16'd0);
    fill(0, 0, 8'h00); send_cw(0); read_cw(0, 0);

    // Abort a pending readout.
    fill(2, 5, 8'h3C); send_cw(0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    chk("flush_out_out_valid", 16'(out_valid), 16'd0);
    chk("flush_out_in_ready", 16'(in_ready), 16'd1);
    chk("flush_out_err_cnt", err_cnt, 16'(exp_err));
    fill(1, 0, 8'h00); send_cw(0); read_cw(0, 0);

    // Asynchronous reset in the middle of a readout.
    fill(2, 30, 8'h01); send_cw(0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_err = 0;
    chk("async_rst_out_valid", 16'(out_valid), 16'd0);
    chk("async_rst_err_cnt", err_cnt, 16'd0);
    chk("async_rst_in_ready", 16'(in_ready), 16'd0);
    chk("async_rst_out_idx", 16'(out_idx), 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("async_rst_exit_in_ready", 16'(in_ready), 16'd1);

    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 5) == 0) fill(0, 0, 8'h00);
      else fill(1, 0, 8'h00);
      send_cw(1);
      read_cw(0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rs_syndrome_calc.md
Name: rs_syndrome_calc

Overview:
- Streaming Reed-Solomon syndrome generator for the CD CIRC decoder path, over GF(256) with polynomial 0x11D and alpha = 0x02.
- Accepts one received codeword of N_SYM bytes (C1: 32, C2: 28) and computes N_SYND syndromes S_j = r(alpha^j), j = 0..N_SYND-1, using Horner's rule with constant GF multipliers.
- Presents the syndromes serially, with a valid/ready handshake, to the downstream error locator.

Parameters:
- N_SYM, 32, symbols per codeword; legal range 2..255.
- N_SYND, 4, number of syndromes (roots alpha^0..alpha^(N_SYND-1)); legal range 1..16.
- GF_POLY, 9'h11D, field generator polynomial.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort: drop partial codeword or pending readout
- in_data  in  8  received symbol, first symbol = highest-degree coefficient
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a symbol
- out_synd  out  8  syndrome value
- out_idx  out  4  syndrome index j
- out_last  out  1  high with j = N_SYND-1
- out_nz  out  1  OR of all N_SYND syndromes of the current codeword; constant during readout
- out_valid  out  1  out_synd/out_idx valid
- out_ready  in  1  consumer accepts
- err_cnt  out  16  codewords with nonzero syndromes (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. While rst_n is low: state = ACC, symbol counter = 0, all accumulators = 0, in_ready = 0, out_valid = 0, out_synd = 0, out_idx = 0, out_last = 0, out_nz = 0, err_cnt = 0.
- Exit from reset: in_ready is 1 in the first cycle after rst_n deasserts.
- State ACC:
  - in_ready = 1, out_valid = 0.
  - On a transfer (in_valid & in_ready), for every j: acc_j <= (acc_j * alpha^j) ^ in_data, and cnt increments. Constant multipliers are elaborated per j; acc_0 reduces to a running XOR.
  - The transfer with cnt = N_SYM-1 sets cnt to 0 and moves to OUT. acc_j then holds S_j.
  - in_valid low: no state change.
- State OUT:
  - in_ready = 0.
  - out_valid = 1 from the first cycle after the last input transfer (latency of 1 cycle).
  - out_synd = acc[out_idx]. out_idx starts at 0 and advances by 1 on each transfer (out_valid & out_ready). out_synd and out_idx hold stable while out_ready is low.
  - On the transfer with out_idx = N_SYND-1: all acc clear to 0, out_idx returns to 0, state returns to ACC. in_ready is 1 the next cycle, so there is one bubble per codeword.
- flush:
  - In ACC or OUT: clears acc, cnt and out_idx, and returns to ACC. in_ready = 1 and out_valid = 0 on the next cycle.
  - An in_valid in the same cycle as flush is discarded.
  - err_cnt is unaffected.
- Asynchronous reset mid-codeword or mid-readout: immediate return to the reset values above. No partial output.
- Width rules:
  - GF addition is XOR.
  - Constant multiplication is shift-and-reduce by GF_POLY.
  - cnt width is clog2(N_SYM). out_idx is zero-extended to 4 bits.

Optional Feature:
- Macro: RS_SYND_ERRCNT_EN.
- Defined:
  - err_cnt increments by 1 on the final output transfer of each codeword with out_nz = 1.
  - err_cnt saturates at 16'hFFFF.
  - err_cnt is cleared only by rst_n.
- Undefined: err_cnt is tied to 16'h0000 and no counter logic is built.

Test Plan:
- N_SYM=32, N_SYND=4, 32 bytes of 0x00, out_ready=1 -> four outputs: idx 0..3, synd 0x00, out_last on idx 3, out_nz=0, err_cnt=0.
- 32 bytes, all 0x00 except byte 30 (second-last) = 0x01 -> synd 0x01, 0x02, 0x04, 0x08, out_nz=1; err_cnt=1 with RS_SYND_ERRCNT_EN, 0 without.
- 32 bytes, all 0x00 except byte 31 = 0x55 -> all four syndromes 0x55.
- out_ready held low 5 cycles during OUT -> idx 0 / synd stable for those 5 cycles, in_ready=0 throughout; the next codeword is accepted only after the idx 3 transfer.
- flush asserted after 10 symbols, then a clean all-zero codeword sent -> syndromes all 0x00. Partial-data residue is a failure.
- rst_n pulsed low mid-readout -> out_valid=0 and err_cnt=0 immediately; in_ready=1 the cycle after release. Back-to-back random codewords are checked against a software GF(256) model.
